// File: rtl/nios_sys_ram_stream_reader.sv
// Streams cmd_len words from a 1-cycle-latency RAM slave onto a valid/ready source.
// Optional: define RAM_READER_WRAP_EN to let bursts wrap from the top word back to 0.
module nios_sys_ram_stream_reader #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [3:0]        ram_byteenable,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic              src_valid,
  input  logic              src_ready,
  output logic [DATA_W-1:0] src_data,
  output logic              src_eop,
  output logic              busy,
  output logic              err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W+1:0] SPAN    = {2'b01, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t             r_state, w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W:0]    r_issue_left;
  logic               r_inflight;
  logic               r_inflight_eop;
  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_eop_q;
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_err;

  logic               w_len_bad, w_bad, w_accept, w_reject;
  logic               w_issue, w_last_issue, w_push, w_pop;
  logic [CNT_W:0]     w_occ;

  assign w_len_bad = (cmd_len == '0) || ({1'b0, cmd_len} > SPAN);
`ifdef RAM_READER_WRAP_EN
  assign w_bad = w_len_bad;
`else
  logic [ADDR_W+1:0] w_end;
  assign w_end = {2'b00, cmd_addr} + {1'b0, cmd_len};
  assign w_bad = w_len_bad || (w_end > SPAN);
`endif

  assign w_accept     = cmd_valid & cmd_ready & ~w_bad;
  assign w_reject     = cmd_valid & cmd_ready & w_bad;
  // Outstanding = buffered words plus the read still returning; never exceeds depth.
  assign w_occ        = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
  assign w_last_issue = (r_issue_left == (ADDR_W+1)'(1));
  assign w_push       = r_inflight;
  assign w_pop        = src_valid & src_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)                      w_next = ST_RUN;
      ST_RUN:   if (w_issue && w_last_issue)       w_next = ST_DRAIN;
      ST_DRAIN: if (w_pop && r_eop_q[r_rd_ptr])    w_next = ST_IDLE;
      default:                                     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = (r_state == ST_IDLE);
    busy           = (r_state != ST_IDLE);
    w_issue        = (r_state == ST_RUN) && (w_occ < DEPTH_C);
    ram_chipselect = w_issue;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr         <= '0;
      r_issue_left   <= '0;
      r_inflight     <= 1'b0;
      r_inflight_eop <= 1'b0;
      r_eop_q        <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_err          <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_accept) begin
        r_addr       <= cmd_addr;
        r_issue_left <= cmd_len;
      end else if (w_issue) begin
        r_addr       <= r_addr + ADDR_W'(1);
        r_issue_left <= r_issue_left - (ADDR_W+1)'(1);
      end
      r_inflight     <= w_issue;
      r_inflight_eop <= w_issue && w_last_issue;
      if (w_push) begin
        r_mem[r_wr_ptr]   <= ram_readdata;
        r_eop_q[r_wr_ptr] <= r_inflight_eop;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_err <= w_reject;
    end
  end

  assign ram_address    = r_addr;
  assign ram_write      = 1'b0;
  assign ram_byteenable = 4'hF;
  assign ram_clken      = 1'b1;
  assign src_valid      = (r_count != '0);
  assign src_data       = r_mem[r_rd_ptr];
  assign src_eop        = src_valid & r_eop_q[r_rd_ptr];
  assign err            = r_err;

endmodule

// File: tb/tb_nios_sys_ram_stream_reader.sv
// Directed bench for nios_sys_ram_stream_reader; RAM model returns 0xA500_0000 | address.
module tb_nios_sys_ram_stream_reader;

  logic        clk = 1'b0;
  logic        reset_n, cmd_valid, cmd_ready;
  logic [11:0] cmd_addr;
  logic [12:0] cmd_len;
  logic [11:0] ram_address;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_readdata;
  logic        src_valid, src_ready, src_eop, busy, err;
  logic [31:0] src_data;

  int n_tests = 0;
  int n_fail  = 0;
  int issued, popped, max_occ, err_cnt;
  logic [11:0] q_addr [$];

  nios_sys_ram_stream_reader #(.ADDR_W(12), .DATA_W(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_address(ram_address),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_byteenable(ram_byteenable), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata), .src_valid(src_valid), .src_ready(src_ready),
    .src_data(src_data), .src_eop(src_eop), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_readdata <= 32'hA500_0000 | {20'h0, ram_address};

  always @(negedge clk) begin
    #2;
    if (issued - popped > max_occ) max_occ = issued - popped;
    if (ram_chipselect) begin
      issued++;
      q_addr.push_back(ram_address);
    end
    if (src_valid && src_ready) popped++;
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    issued = 0; popped = 0; max_occ = 0; err_cnt = 0;
    q_addr.delete();
  endtask

  task automatic send_cmd(input logic [11:0] a, input logic [12:0] l);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // mode 0: src_ready held high, also checks per-word timing; mode 1: ready toggles.
  task automatic collect(input string tag, input logic [11:0] a, input int len, input int mode);
    int k = 0;
    int got = 0;
    logic [11:0] wa;
    while (got < len && k < 3 * len + 20) begin
      @(negedge clk);
      src_ready = (mode == 0) ? 1'b1 : ((k % 2) == 0);
      #1;
      if (src_valid && src_ready) begin
        wa = a + got[11:0];
        check({tag, "_data"}, src_data, 32'hA500_0000 | {20'h0, wa});
        check({tag, "_eop"}, src_eop, got == len - 1);
        if (mode == 0) check({tag, "_time"}, k, 2 + got);
        got++;
        if (got == len) cmd_valid = 1'b0;
      end
      k++;
    end
    check({tag, "_count"}, got, len);
    @(negedge clk); #1;
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_ready_after"}, cmd_ready, 1);
    check({tag, "_issued"}, q_addr.size(), len);
    for (int i = 0; i < len && i < 64; i++)
      if (i < q_addr.size()) check({tag, "_addr"}, q_addr[i], a + 12'(i));
    check({tag, "_occ_le4"}, max_occ <= 4, 1);
    src_ready = 1'b0;
  endtask

  task automatic expect_reject(input string tag, input logic [11:0] a, input logic [12:0] l);
    clear_mon();
    send_cmd(a, l);
    @(negedge clk); #1;
    check({tag, "_err_hi"}, err, 1);
    check({tag, "_busy"}, busy, 0);
    @(negedge clk); #1;
    check({tag, "_err_lo"}, err, 0);
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_no_cs"}, issued, 0);
  endtask

  initial begin
    int got;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; src_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_src_valid", src_valid, 0);
    check("rst_src_eop", src_eop, 0);
    check("rst_src_data", src_data, 0);
    check("rst_cs", ram_chipselect, 0);
    check("rst_addr", ram_address, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_const", {ram_write, ram_byteenable, ram_clken}, 6'b0_1111_1);
    reset_n = 1'b1;
    @(negedge clk); #1;
    check("rst_cmd_ready", cmd_ready, 1);

    clear_mon();
    send_cmd(12'h010, 13'd4);
    collect("basic", 12'h010, 4, 0);

    // Commands presented while busy must be ignored (len 0 would otherwise pulse err).
    clear_mon();
    send_cmd(12'h100, 13'd8);
    cmd_valid = 1'b1; cmd_len = 13'd0;
    collect("toggle", 12'h100, 8, 1);
    check("toggle_cmd_ignored", err_cnt, 0);

    expect_reject("len0", 12'h000, 13'd0);
    expect_reject("len4097", 12'h000, 13'd4097);

    clear_mon();
    send_cmd(12'h005, 13'd1);
    collect("len1", 12'h005, 1, 0);

    clear_mon();
    send_cmd(12'hFFC, 13'd4);
    collect("top_edge", 12'hFFC, 4, 0);

`ifdef RAM_READER_WRAP_EN
    clear_mon();
    send_cmd(12'hFFE, 13'd4);
    collect("wrap", 12'hFFE, 4, 0);
`else
    expect_reject("nowrap", 12'hFFE, 13'd4);
`endif

    clear_mon();
    send_cmd(12'h000, 13'd4096);
    collect("full_len", 12'h000, 4096, 0);

    clear_mon();
    send_cmd(12'h200, 13'd16);
    src_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && got < 3; k++) begin
      @(negedge clk); #1;
      if (src_valid && src_ready) begin
        check("mid_data", src_data, 32'hA500_0200 + got);
        got++;
      end
    end
    check("mid_count", got, 3);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1; #1;
    check("mid_rst_valid", src_valid, 0);
    check("mid_rst_eop", src_eop, 0);
    check("mid_rst_data", src_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_cs", ram_chipselect, 0);
    src_ready = 1'b0;
    clear_mon();
    send_cmd(12'h040, 13'd3);
    collect("after_rst", 12'h040, 3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_sys_ram_stream_reader.md
NIOS_SYS_RAM_STREAM_READER -- requirements
Module: nios_sys_ram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning RAM word-address width (4096 words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning RAM/stream data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries (power of 2, >=2).
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port cmd_valid  input  1  command request.
REQ-008 SHALL have port cmd_ready  output  1  high only in IDLE.
REQ-009 SHALL have port cmd_addr  input  ADDR_W  first word address.
REQ-010 SHALL have port cmd_len  input  ADDR_W+1  word count, 1..4096.
REQ-011 SHALL have port ram_address  output  ADDR_W  word address to RAM slave.
REQ-012 SHALL have port ram_chipselect  output  1  asserted on each issued read.
REQ-013 SHALL have port ram_write  output  1  constant 0.
REQ-014 SHALL have port ram_byteenable  output  4  constant 4'hF.
REQ-015 SHALL have port ram_clken  output  1  constant 1.
REQ-016 SHALL have port ram_readdata  input  DATA_W  RAM read data, valid 1 cycle after issue.
REQ-017 SHALL have port src_valid / src_ready / src_data[DATA_W] / src_eop  out/in/out/out  streaming source.
REQ-018 SHALL have port busy  output  1  high in RUN or DRAIN.
REQ-019 SHALL have port err  output  1  one-cycle pulse on rejected command.

Function
REQ-020 SHALL accept a command on a cycle with cmd_valid & cmd_ready; cmd_addr and cmd_len captured that edge.
REQ-021 SHALL implement states IDLE, RUN, DRAIN: IDLE->RUN on accept; RUN->DRAIN after last read issued; DRAIN->IDLE after last word (src_eop) transferred.
REQ-022 SHALL, in RUN, issue a read (ram_chipselect=1) only when fifo_count + in_flight < FIFO_DEPTH; ram_address increments by 1 per issued read.
REQ-023 SHALL treat read latency as exactly 1 cycle: ram_readdata sampled into FIFO the cycle after issue, regardless of src_ready.
REQ-024 SHALL present FIFO head on src_data with src_valid=1 while FIFO non-empty; pop on src_valid & src_ready; src_data stable while stalled.
REQ-025 SHALL assert src_eop with the cmd_len-th word only.
REQ-026 SHALL support simultaneous FIFO push and pop in one cycle, count unchanged, including when full with pop.
REQ-027 SHALL sustain one word per cycle with src_ready held high; first src_valid 2 cycles after accept.
REQ-028 SHALL reject cmd_len==0 or cmd_len>4096: err=1 one cycle, stay IDLE, no RAM access.
REQ-029 SHALL keep cmd_ready low in RUN/DRAIN; cmd_valid there is ignored.

Reset
REQ-030 SHALL, on reset_n=0 at a clock edge, go to IDLE, flush FIFO and in-flight read, abort any command mid-operation.
REQ-031 SHALL reset outputs: cmd_ready=1 (after release), src_valid=0, src_eop=0, src_data=0, ram_chipselect=0, ram_address=0, busy=0, err=0.

Configuration
REQ-032 SHALL honour macro RAM_READER_WRAP_EN: defined -> addresses wrap 4095->0 modulo 2^ADDR_W; undefined -> cmd_addr+cmd_len>4096 rejected per REQ-028.

Verification
REQ-033 SHALL cover: addr=0x010, len=4, src_ready=1 -> words mem[0x010..0x013] on 4 consecutive cycles, eop on 4th, busy low after.
REQ-034 SHALL cover: len=8, src_ready toggling 1/0 -> 8 words in order, none lost/duplicated, in_flight+count never >4.
REQ-035 SHALL cover: len=0 and len=4097 -> err pulse 1 cycle, ram_chipselect never high.
REQ-036 SHALL cover: addr=0xFFE, len=4 -> with RAM_READER_WRAP_EN reads 0xFFE,0xFFF,0x000,0x001; without it err pulse.
REQ-037 SHALL cover: reset_n low for 1 cycle after 3rd word of len=16 -> src_valid=0 next cycle, cmd_ready=1, new command works.
